// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Strobes are decoded for the state being entered and registered, so every output except pc_en_o is a clean Moore signal.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_ctrl_o,
  output logic       ext_op_o,
  output logic [1:0] pc_source_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_MA   = 4'd3,
    S_MRD  = 4'd4,
    S_MWB  = 4'd5,
    S_MWR  = 4'd6,
    S_REX  = 4'd7,
    S_RWB  = 4'd8,
    S_IEX  = 4'd9,
    S_IWB  = 4'd10,
    S_BR   = 4'd11,
    S_JMP  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef struct packed {
    logic       pc_write;
    logic       branch_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       ext_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic rtype_valid(input logic [5:0] fn);
    logic ok;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    logic [2:0] alu;
    case (op)
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // Logical immediates zero-extend; everything else that uses the extender sign-extends.
  function automatic logic imm_sign(input logic [5:0] op);
    logic sgn;
    if ((op == OP_ANDI) || (op == OP_ORI)) begin
      sgn = 1'b0;
    end else begin
      sgn = 1'b1;
    end
    return sgn;
  endfunction

  function automatic ctrl_t decode(input state_e st, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (st)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_ID: begin
        c.alu_src_b = 2'b11;
        c.ext_op    = 1'b1;
      end
      S_MA: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
      end
      S_MRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_REX: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = rtype_alu(fn);
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_ctrl  = rtype_alu(fn);
      end
      S_IEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.ext_op    = imm_sign(op);
        c.alu_ctrl  = imm_alu(op);
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        c.ext_op    = imm_sign(op);
        c.alu_ctrl  = imm_alu(op);
      end
      S_BR: begin
        c.alu_src_a   = 1'b1;
        c.alu_ctrl    = ALU_SUB;
        c.branch_cond = 1'b1;
        c.pc_source   = 2'b01;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state selection; opcode and funct are held stable by the IR from ID onward.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        case (opcode_i)
          OP_RTYPE:                 state_d = S_REX;
          OP_LW, OP_SW:             state_d = S_MA;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEX;
          OP_BEQ:                   state_d = S_BR;
          OP_J:                     state_d = S_JMP;
          default:                  state_d = S_IF;
        endcase
      end
      S_MA: begin
        if (opcode_i == OP_SW) begin
          state_d = S_MWR;
        end else begin
          state_d = S_MRD;
        end
      end
      S_MRD: state_d = S_MWB;
      S_REX: begin
        if (rtype_valid(funct_i)) begin
          state_d = S_RWB;
        end else begin
          state_d = S_IF;
        end
      end
      S_IEX:   state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  // Output decode for the state about to be entered.
  always_comb begin
    ctrl_d = decode(state_d, opcode_i, funct_i);
  end

  // State and registered strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign pc_en_o      = ctrl_q.pc_write | (ctrl_q.branch_cond & zero_i);
  assign iord_o       = ctrl_q.iord;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign ir_write_o   = ctrl_q.ir_write;
  assign reg_dst_o    = ctrl_q.reg_dst;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign reg_write_o  = ctrl_q.reg_write;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign alu_ctrl_o   = ctrl_q.alu_ctrl;
  assign ext_op_o     = ctrl_q.ext_op;
  assign pc_source_o  = ctrl_q.pc_source;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level table, reset abort sequence and random instruction stream
// checked against an instruction-path / per-state strobe model.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, ext_op_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_ctrl_o;
  logic [3:0] state_o;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i), .zero_i(zero_i),
    .pc_en_o(pc_en_o), .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_ctrl_o(alu_ctrl_o), .ext_op_o(ext_op_o), .pc_source_o(pc_source_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, BEQ = 6'b000100, J = 6'b000010;

  logic [16:0] dut_v;
  assign dut_v = {pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
                  reg_write_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o, ext_op_o, pc_source_o};

  int n_pass = 0;
  int n_total = 0;
  int path_q[$];

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         zmode;
    int         cpi;
    logic       chk_alu;
    logic [2:0] alu;
    logic       ext;
    logic       pcen;
    logic [1:0] pcs;
    logic       wr;
  } vec_t;
  vec_t vq[$];

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ALU op code of an R-type funct, -1 when the funct is not supported.
  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 0;
      6'b100010: return 1;
      6'b100100: return 2;
      6'b100101: return 3;
      6'b101010: return 4;
      default:   return -1;
    endcase
  endfunction

  // States visited by one instruction, starting at IF.
  task automatic load_path(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      LW:             path_q = '{1, 2, 3, 4, 5};
      SW:             path_q = '{1, 2, 3, 6};
      RT:             if (r_alu(fn) >= 0) path_q = '{1, 2, 7, 8}; else path_q = '{1, 2, 7};
      ADDI, ANDI, ORI: path_q = '{1, 2, 9, 10};
      BEQ:            path_q = '{1, 2, 11};
      J:              path_q = '{1, 2, 12};
      default:        path_q = '{1, 2};
    endcase
  endtask

  function automatic logic [16:0] exp_vec(input int st, input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic pcw = 1'b0, br = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0;
    logic rdst = 1'b0, m2r = 1'b0, rw = 1'b0, asa = 1'b0, ext = 1'b0;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b000;
    case (st)
      1:  begin mrd = 1'b1; irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
      2:  begin asb = 2'b11; ext = 1'b1; end
      3:  begin asa = 1'b1; asb = 2'b10; ext = 1'b1; end
      4:  begin mrd = 1'b1; iord = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mwr = 1'b1; iord = 1'b1; end
      7:  begin asa = 1'b1; if (r_alu(fn) >= 0) alu = 3'(r_alu(fn)); end
      8:  begin rw = 1'b1; rdst = 1'b1; alu = 3'(r_alu(fn)); end
      9, 10: begin
        if (st == 9) begin asa = 1'b1; asb = 2'b10; end
        else rw = 1'b1;
        if (op == ADDI) begin alu = 3'b000; ext = 1'b1; end
        else if (op == ANDI) alu = 3'b010;
        else alu = 3'b011;
      end
      11: begin asa = 1'b1; alu = 3'b001; br = 1'b1; pcs = 2'b01; end
      12: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw | (br & z), iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, alu, ext, pcs};
  endfunction

  // ALU op is left free in REX for an unsupported funct.
  function automatic logic [16:0] exp_mask(input int st, input logic [5:0] fn);
    if (st == 7 && r_alu(fn) < 0) return ~17'h00038;
    return 17'h1FFFF;
  endfunction

  task automatic step_check(input int exp_st, input logic z);
    logic [16:0] e, m;
    @(posedge clk_i);
    #1 zero_i = z;
    #1;
    check_int("state", int'(state_o), exp_st);
    e = exp_vec(exp_st, opcode_i, funct_i, z);
    m = exp_mask(exp_st, funct_i);
    n_total++;
    if (((dut_v ^ e) & m) == 17'h0) n_pass++;
    else $display("FAIL outputs st=%0d op=%b fn=%b: got %h expected %h", exp_st, opcode_i, funct_i, dut_v & m, e & m);
  endtask

  // Runs one instruction from its IF cycle (already sampled) up to and including the next IF.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           output int cyc, output logic [2:0] x_alu, output logic x_ext,
                           output logic x_pcen, output logic [1:0] x_pcs, output logic wr);
    logic z;
    opcode_i = op;
    funct_i  = fn;
    load_path(op, fn);
    cyc = 0; wr = 1'b0; x_alu = 3'b000; x_ext = 1'b0; x_pcen = 1'b0; x_pcs = 2'b00;
    for (int k = 1; k < 8; k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      step_check((k < path_q.size()) ? path_q[k] : 1, z);
      if (k == 2) begin
        x_alu = alu_ctrl_o; x_ext = ext_op_o; x_pcen = pc_en_o; x_pcs = pc_source_o;
      end
      if (reg_write_o) wr = 1'b1;
      if (state_o == 4'd1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn, input int zmode,
                         input int cpi, input logic chk_alu, input logic [2:0] alu, input logic ext,
                         input logic pcen, input logic [1:0] pcs, input logic wr);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.zmode = zmode; v.cpi = cpi; v.chk_alu = chk_alu;
    v.alu = alu; v.ext = ext; v.pcen = pcen; v.pcs = pcs; v.wr = wr;
    vq.push_back(v);
  endtask

  initial begin
    int cyc;
    logic [2:0] x_alu;
    logic x_ext, x_pcen, wr;
    logic [1:0] x_pcs;
    logic [5:0] pool [9];

    // name, op, funct, zero, cpi, chk_alu, alu/ext/pc_en/pc_source in the third state, any reg_write
    add_vec("lw",      LW,   6'b000000, 0, 5, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1);
    add_vec("sw",      SW,   6'b000000, 0, 4, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0);
    add_vec("add",     RT,   6'b100000, 0, 4, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("sub",     RT,   6'b100010, 0, 4, 1'b1, 3'b001, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("and",     RT,   6'b100100, 0, 4, 1'b1, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("or",      RT,   6'b100101, 0, 4, 1'b1, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("slt",     RT,   6'b101010, 0, 4, 1'b1, 3'b100, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("bad_fn",  RT,   6'b001000, 0, 3, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0);
    add_vec("ori",     ORI,  6'b000000, 0, 4, 1'b1, 3'b011, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("addi",    ADDI, 6'b000000, 0, 4, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b1);
    add_vec("andi",    ANDI, 6'b000000, 0, 4, 1'b1, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1);
    add_vec("beq_z1",  BEQ,  6'b000000, 1, 3, 1'b1, 3'b001, 1'b0, 1'b1, 2'b01, 1'b0);
    add_vec("beq_z0",  BEQ,  6'b000000, 0, 3, 1'b1, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0);
    add_vec("j",       J,    6'b000000, 0, 3, 1'b1, 3'b000, 1'b0, 1'b1, 2'b10, 1'b0);
    add_vec("unknown", 6'b111111, 6'b000000, 0, 2, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0);

    rst_i = 1'b1; opcode_i = 6'b000000; funct_i = 6'b000000; zero_i = 1'b1;
    #12;
    check_int("reset_state", int'(state_o), 0);
    check_int("reset_outputs", int'(dut_v), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step_check(1, 1'b0);

    foreach (vq[i]) begin
      run_instr(vq[i].op, vq[i].fn, vq[i].zmode, cyc, x_alu, x_ext, x_pcen, x_pcs, wr);
      check_int({vq[i].name, "_cpi"}, cyc, vq[i].cpi);
      if (vq[i].chk_alu) check_int({vq[i].name, "_alu"}, int'(x_alu), int'(vq[i].alu));
      check_int({vq[i].name, "_ext"}, int'(x_ext), int'(vq[i].ext));
      check_int({vq[i].name, "_pc_en"}, int'(x_pcen), int'(vq[i].pcen));
      check_int({vq[i].name, "_pc_source"}, int'(x_pcs), int'(vq[i].pcs));
      check_int({vq[i].name, "_reg_write"}, int'(wr), int'(vq[i].wr));
    end

    // lw aborted by reset while in MRD
    opcode_i = LW; funct_i = 6'b000000;
    step_check(2, 1'b0);
    step_check(3, 1'b0);
    step_check(4, 1'b0);
    #2 rst_i = 1'b1; zero_i = 1'b1;
    #1;
    check_int("abort_state", int'(state_o), 0);
    check_int("abort_outputs", int'(dut_v), 0);
    #20;
    check_int("abort_no_write", int'(reg_write_o | mem_write_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step_check(1, 1'b0);
    step_check(2, 1'b0);
    step_check(3, 1'b0);
    step_check(4, 1'b0);
    step_check(5, 1'b0);
    step_check(1, 1'b0);

    pool = '{LW, SW, RT, ADDI, ANDI, ORI, BEQ, J, 6'b111111};
    for (int n = 0; n < 120; n++) begin
      logic [5:0] op, fn;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
      else op = pool[$urandom_range(0, 8)];
      fn = 6'($urandom_range(0, 63));
      if (op == RT && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 4))
          0: fn = 6'b100000;
          1: fn = 6'b100010;
          2: fn = 6'b100100;
          3: fn = 6'b100101;
          default: fn = 6'b101010;
        endcase
      end
      run_instr(op, fn, 2, cyc, x_alu, x_ext, x_pcen, x_pcs, wr);
      check_int("rand_cpi", cyc, path_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style main control FSM for the multicycle MIPS datapath. It decodes the instruction-register opcode and funct fields and sequences one instruction at a time through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath strobes and mux selects, including `ext_op`, which selects sign or zero extension of the 16-bit immediate. It sits between the instruction register and the shared memory / register-file / ALU datapath.

## Interface
Parameters: none.

Ports (all outputs are a function of the current state only, except `pc_en`):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; forces state `INIT`.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0]; used only when `opcode` = 000000.
- `zero`  in  1  ALU zero flag from the current cycle.
- `pc_en`  out  1  PC load enable. Combinational: `pc_write | (branch_cond & zero)`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load enable.
- `reg_dst`  out  1  write-register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  ALU operand A: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `alu_ctrl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `ext_op`  out  1  extender mode: 1 = sign-extend, 0 = zero-extend.
- `pc_source`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}.
- `state`  out  4  current state encoding, for debug.

## Operation
State encodings:
- INIT=0, IF=1, ID=2, MA=3, MRD=4, MWB=5, MWR=6, REX=7, RWB=8, IEX=9, IWB=10, BR=11, JMP=12.
- Encodings 13–15 are illegal and go to IF on the next edge.

Default output value is 0 in every state unless listed below.
- **INIT:** all outputs 0. Next state is IF.
- **IF:**
  - Signals: `mem_read`=1, `ir_write`=1, `pc_write`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_ctrl`=add, `pc_source`=00.
  - Next state is ID.
- **ID:**
  - Signals: `alu_src_a`=0, `alu_src_b`=11, `ext_op`=1, `alu_ctrl`=add. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 000000 → REX
    - 100011 (lw) or 101011 (sw) → MA
    - 001000 (addi), 001100 (andi), 001101 (ori) → IEX
    - 000100 (beq) → BR
    - 000010 (j) → JMP
    - any other opcode → IF (executes as a no-op; no writes occur).
- **MA:** `alu_src_a`=1, `alu_src_b`=10, `ext_op`=1, `alu_ctrl`=add. Next state is MRD for lw, MWR for sw.
- **MRD:** `mem_read`=1, `iord`=1. Next state is MWB.
- **MWB:** `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state is IF.
- **MWR:** `mem_write`=1, `iord`=1. Next state is IF.
- **REX:**
  - Signals: `alu_src_a`=1, `alu_src_b`=00.
  - `alu_ctrl` from funct: 100000→add, 100010→sub, 100100→and, 100101→or, 101010→slt.
  - Next state is RWB for a listed funct. Any unlisted funct goes to IF with no write.
- **RWB:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Hold `alu_ctrl` at the REX value. Next state is IF.
- **IEX:**
  - Signals: `alu_src_a`=1, `alu_src_b`=10.
  - addi: `ext_op`=1, `alu_ctrl`=add.
  - andi: `ext_op`=0, `alu_ctrl`=and.
  - ori: `ext_op`=0, `alu_ctrl`=or.
  - Next state is IWB.
- **IWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Hold `ext_op` and `alu_ctrl` at the IEX values. Next state is IF.
- **BR:** `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl`=sub, `branch_cond`=1, `pc_source`=01. Next state is IF.
- **JMP:** `pc_write`=1, `pc_source`=10. Next state is IF.

Rules:
- `mem_read` and `mem_write` are never both 1.
- `reg_write` is never asserted outside MWB, RWB and IWB.
- `opcode` and `funct` are sampled combinationally. The IR must hold them stable from ID until the instruction returns to IF.

## Timing
- Reset:
  - `rst`=1 forces state INIT immediately (asynchronously).
  - Every output is 0 while in INIT, including `pc_en`.
  - The first IF occurs on the first rising edge after `rst` falls.
  - Asserting `rst` mid-instruction aborts it; no further write strobe is issued.
- Cycles per instruction, counted from entering IF to the next IF:
  - lw: 5.
  - R-type, addi/andi/ori, sw: 4.
  - beq, j: 3.
  - Unknown opcode: 2.
- `pc_en` follows `zero` within the same cycle in BR. When `zero`=0, the PC is not written.
- There are no stall inputs; the memory is single-cycle.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` asynchronously mid-cycle in state MRD.
  - Required: `state`=0 and all outputs 0 before the next edge. After release, state sequence 1, 2.
- **lw** (`opcode`=100011):
  - Required state sequence: 1, 2, 3, 4, 5, 1.
  - In MA: `ext_op`=1, `alu_src_b`=10.
  - In MWB: `mem_to_reg`=1, `reg_write`=1.
- **R-type with funct 101010 (slt):**
  - Required state sequence: 1, 2, 7, 8, 1.
  - `alu_ctrl`=100 in REX and RWB; `reg_dst`=1 in RWB.
  - With funct 001000 instead: sequence 1, 2, 7, 1 and `reg_write` never 1.
- **ori** (`opcode`=001101):
  - Required state sequence: 1, 2, 9, 10, 1.
  - `ext_op`=0 and `alu_ctrl`=011 in IEX and IWB.
  - addi repeated with the same sequence: `ext_op`=1 and `alu_ctrl`=000.
- **beq:**
  - In BR with `zero`=1: `pc_en`=1, `pc_source`=01.
  - In BR with `zero`=0: `pc_en`=0.
  - Required state sequence: 1, 2, 11, 1.
- **j and unknown opcode:**
  - j: sequence 1, 2, 12, 1, with `pc_en`=1 and `pc_source`=10 in JMP.
  - Opcode 111111: sequence 1, 2, 1, with no `mem_write` or `reg_write` asserted.
